// File: rtl/board_input_conditioner_if.sv
// board_input_conditioner_if: raw board pins in, conditioned levels and edge pulses out.
interface board_input_conditioner_if #(
  parameter int w_key = 2,
  parameter int w_sw  = 3
);
  logic [w_key-1:0] key_raw, key, key_press, key_release;
  logic [w_sw-1:0]  sw_raw, sw, sw_change;
  logic             long_rst;
  modport master (output key_raw, sw_raw, input key, sw, key_press, key_release, sw_change, long_rst);
  modport slave  (input key_raw, sw_raw, output key, sw, key_press, key_release, sw_change, long_rst);
endinterface

// File: rtl/board_input_conditioner.sv
// board_input_conditioner: polarity-normalise, synchronise and debounce board keys/switches,
// derive one-cycle edge pulses and a long-press reset request from the last key.
module board_input_conditioner #(
  parameter int w_key       = 2,
  parameter int w_sw        = 3,
  parameter int key_act_low = 1,
  parameter int sw_act_low  = 1,
  parameter int db_cycles   = 270000,
  parameter int hold_cycles = 27000000
) (
  input logic clk,
  input logic rst,
  board_input_conditioner_if.slave bus
);
  localparam int w  = w_key + w_sw;
  localparam int cw = $clog2(db_cycles + 1);
  localparam int hw = $clog2(hold_cycles + 1);
  localparam logic [cw-1:0] db_last  = cw'(db_cycles - 1);
  localparam logic [hw-1:0] hold_max = hw'(hold_cycles);
  logic [w-1:0]          n, s1_q, s_q, lvl_q, lvl_d, chg_q, chg_d;
  logic [w-1:0][cw-1:0]  cnt_q, cnt_d;
  logic [hw-1:0]         hcnt_q, hcnt_d;
  logic                  lrst_q, lrst_d, hold_key;
  // keys occupy the low bits, switches the high bits, all active-high from here on
  assign n = {bus.sw_raw ^ {w_sw{sw_act_low != 0}}, bus.key_raw ^ {w_key{key_act_low != 0}}};
  always_comb begin
    for (int i = 0; i < w; i++) chg_d[i] = s_q[i] != lvl_q[i] && cnt_q[i] == db_last;
  end
  always_comb begin
    for (int i = 0; i < w; i++) begin
      cnt_d[i] = (s_q[i] == lvl_q[i] || chg_d[i]) ? '0 : cnt_q[i] + cw'(1);
      lvl_d[i] = chg_d[i] ? s_q[i] : lvl_q[i];
    end
  end
  assign hold_key = lvl_q[w_key-1];
  always_comb begin
    hcnt_d = !hold_key ? '0 : hcnt_q == hold_max ? hcnt_q : hcnt_q + hw'(1);
    lrst_d = hold_key && hcnt_q == hold_max;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s_q    <= '0;
      lvl_q  <= '0;
      chg_q  <= '0;
      cnt_q  <= '0;
      hcnt_q <= '0;
      lrst_q <= 1'b0;
    end else begin
      s1_q   <= n;
      s_q    <= s1_q;
      lvl_q  <= lvl_d;
      chg_q  <= chg_d;
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
      lrst_q <= lrst_d;
    end
  end
  // pulses come from the change flag registered alongside the new level
  assign bus.key         = lvl_q[w_key-1:0];
  assign bus.sw          = lvl_q[w-1:w_key];
  assign bus.key_press   = chg_q[w_key-1:0] & lvl_q[w_key-1:0];
  assign bus.key_release = chg_q[w_key-1:0] & ~lvl_q[w_key-1:0];
  assign bus.sw_change   = chg_q[w-1:w_key];
  assign bus.long_rst    = lrst_q;
endmodule

// File: tb/tb_board_input_conditioner.sv
// tb_board_input_conditioner: directed and random checks of the conditioner against a
// sample-window reference model (level flips after DB consecutive opposing synced samples).
module tb_board_input_conditioner;
  localparam int WK = 2, WS = 3, W = 5, DB = 4, HOLD = 16;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0, cyc = 0, np0 = 0, nr0 = 0, hrun = 0;
  logic [W-1:0] nh[$], dh[$];
  logic [W-1:0] m_lvl, m_pulse, prev_p;
  logic m_lr;
  board_input_conditioner_if #(.w_key(WK), .w_sw(WS)) bus ();
  board_input_conditioner #(.w_key(WK), .w_sw(WS), .key_act_low(1), .sw_act_low(1),
    .db_cycles(DB), .hold_cycles(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic m_reset;
    nh.delete();
    nh.push_back('0);
    nh.push_back('0);
    dh.delete();
    m_lvl = '0;
    m_pulse = '0;
    m_lr = 0;
    hrun = 0;
  endtask
  task automatic m_edge;
    logic [W-1:0] d, nl;
    bit all;
    if (rst) m_reset();
    else begin
      m_lr = hrun > HOLD;
      nh.push_back(~{bus.sw_raw, bus.key_raw});
      d = nh.pop_front();
      dh.push_back(d);
      if (dh.size() > DB) void'(dh.pop_front());
      for (int i = 0; i < W; i++) begin
        all = dh.size() == DB;
        for (int j = 0; j < dh.size(); j++) if (dh[j][i] == m_lvl[i]) all = 0;
        nl[i] = all ? ~m_lvl[i] : m_lvl[i];
      end
      m_pulse = nl ^ m_lvl;
      m_lvl = nl;
      hrun = m_lvl[WK-1] ? hrun + 1 : 0;
    end
  endtask
  task automatic compare;
    logic [W-1:0] p;
    chk("key", 32'(bus.key), 32'(m_lvl[WK-1:0]));
    chk("sw", 32'(bus.sw), 32'(m_lvl[W-1:WK]));
    chk("key_press", 32'(bus.key_press), 32'(m_pulse[WK-1:0] & m_lvl[WK-1:0]));
    chk("key_release", 32'(bus.key_release), 32'(m_pulse[WK-1:0] & ~m_lvl[WK-1:0]));
    chk("sw_change", 32'(bus.sw_change), 32'(m_pulse[W-1:WK]));
    chk("long_rst", 32'(bus.long_rst), 32'(m_lr));
    p = {bus.sw_change, bus.key_press | bus.key_release};
    chk("double_pulse", 32'(p & prev_p), 0);
    prev_p = p;
    np0 += 32'(bus.key_press[0]);
    nr0 += 32'(bus.key_release[0]);
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      m_edge();
      #1;
      compare();
    end
  endtask
  initial begin
    logic [W-1:0] r;
    bus.key_raw = '1;
    bus.sw_raw = '1;
    prev_p = '0;
    m_reset();
    step(2);
    chk("reset outs", 32'({bus.key, bus.sw, bus.key_press, bus.key_release, bus.sw_change, bus.long_rst}), 0);
    rst = 0;
    bus.key_raw[0] = 0;
    step(5);
    chk("t1 key0 early", 32'(bus.key[0]), 0);
    step(1);
    chk("t1 key0", 32'(bus.key[0]), 1);
    chk("t1 press0", 32'(bus.key_press[0]), 1);
    step(1);
    chk("t1 press0 low", 32'(bus.key_press[0]), 0);
    bus.key_raw[0] = 1;
    step(8);
    np0 = 0;
    nr0 = 0;
    bus.key_raw[0] = 0;
    step(3);
    bus.key_raw[0] = 1;
    step(10);
    chk("t2 glitch3 press", np0, 0);
    chk("t2 glitch3 key", 32'(bus.key[0]), 0);
    bus.key_raw[0] = 0;
    step(5);
    bus.key_raw[0] = 1;
    step(10);
    chk("t2 glitch5 press", np0, 1);
    chk("t2 glitch5 release", nr0, 1);
    bus.sw_raw = 3'b010;
    step(5);
    chk("t3 sw early", 32'(bus.sw), 0);
    step(1);
    chk("t3 sw", 32'(bus.sw), 5);
    chk("t3 sw_change", 32'(bus.sw_change), 5);
    step(1);
    chk("t3 sw_change low", 32'(bus.sw_change), 0);
    bus.key_raw[1] = 0;
    step(6);
    chk("t4 key1", 32'(bus.key[1]), 1);
    step(16);
    chk("t4 long_rst early", 32'(bus.long_rst), 0);
    step(1);
    chk("t4 long_rst", 32'(bus.long_rst), 1);
    step(4);
    bus.key_raw[1] = 1;
    step(6);
    chk("t4 key1 fall", 32'(bus.key[1]), 0);
    chk("t4 long_rst held", 32'(bus.long_rst), 1);
    step(1);
    chk("t4 long_rst drop", 32'(bus.long_rst), 0);
    bus.key_raw[1] = 0;
    step(16);
    rst = 1;
    m_reset();
    prev_p = '0;
    #1;
    compare();
    chk("t5 async outs", 32'({bus.key, bus.sw, bus.key_press, bus.key_release, bus.sw_change, bus.long_rst}), 0);
    step(2);
    rst = 0;
    step(5);
    chk("t5 press1 early", 32'(bus.key_press[1]), 0);
    step(1);
    chk("t5 press1", 32'(bus.key_press[1]), 1);
    chk("t5 sw_change", 32'(bus.sw_change), 5);
    step(16);
    chk("t5 long_rst early", 32'(bus.long_rst), 0);
    step(1);
    chk("t5 long_rst", 32'(bus.long_rst), 1);
    bus.key_raw[1] = 1;
    step(10);
    for (int c = 0; c < 1500; c++) begin
      r = {bus.sw_raw, bus.key_raw};
      for (int b = 0; b < W; b++) if ($urandom_range(5) == 0) r[b] = ~r[b];
      {bus.sw_raw, bus.key_raw} = r;
      step(1);
    end
    step(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
